// File: rtl/stopwatch_bcd.sv
// BCD MM:SS.hh stopwatch core clocked by the 10 MHz master clock.
// Edge-detects the 100 Hz tick and debounced controls in-domain.
module stopwatch_bcd #(
  parameter int MIN_WRAP = 60
) (
  input  logic       CLOCK_10MHz,
  input  logic       RESET_N,
  input  logic       CLOCK_100Hz,
  input  logic       START_STOP,
  input  logic       LAP,
  input  logic       CLEAR,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_U,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_U,
  output logic [3:0] HUN_T,
  output logic [3:0] HUN_U,
  output logic       RUNNING,
  output logic       LAP_HOLD,
  output logic       WRAP
);

  localparam logic [3:0] MT_MAX = 4'((MIN_WRAP - 1) / 10);
  localparam logic [3:0] MU_MAX = 4'((MIN_WRAP - 1) % 10);

  logic       r_p100, r_pss, r_plap, r_pclr;
  logic       r_run, r_hold, r_wrap;
  logic [3:0] r_mt, r_mu, r_st, r_su, r_ht, r_hu;
  logic [3:0] r_dmt, r_dmu, r_dst, r_dsu, r_dht, r_dhu;

  logic w_tick, w_ss, w_lap, w_clr;
  logic w_c0, w_c1, w_c2, w_c3, w_c4;
  logic w_min_top, w_mu_roll, w_wrap;

  assign w_tick = CLOCK_100Hz & ~r_p100;
  assign w_ss   = START_STOP  & ~r_pss;
  assign w_lap  = LAP         & ~r_plap;
  assign w_clr  = CLEAR       & ~r_pclr;

  assign w_c0 = w_tick & r_run;
  assign w_c1 = w_c0 & (r_hu == 4'd9);
  assign w_c2 = w_c1 & (r_ht == 4'd9);
  assign w_c3 = w_c2 & (r_su == 4'd9);
  assign w_c4 = w_c3 & (r_st == 4'd5);

  assign w_min_top = (r_mt == MT_MAX) && (r_mu == MU_MAX);
  assign w_mu_roll = w_min_top || (r_mu == 4'd9);
  assign w_wrap    = w_c4 & w_min_top;

  function automatic logic [3:0] f_inc(
    input logic [3:0] d,
    input logic [3:0] m
  );
    return (d == m) ? 4'd0 : d + 4'd1;
  endfunction

  always_ff @(posedge CLOCK_10MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      r_p100 <= 1'b1;
      r_pss  <= 1'b1;
      r_plap <= 1'b1;
      r_pclr <= 1'b1;
      r_run  <= 1'b0;
      r_hold <= 1'b0;
      r_wrap <= 1'b0;
      r_mt   <= '0;
      r_mu   <= '0;
      r_st   <= '0;
      r_su   <= '0;
      r_ht   <= '0;
      r_hu   <= '0;
      r_dmt  <= '0;
      r_dmu  <= '0;
      r_dst  <= '0;
      r_dsu  <= '0;
      r_dht  <= '0;
      r_dhu  <= '0;
    end else begin
      r_p100 <= CLOCK_100Hz;
      r_pss  <= START_STOP;
      r_plap <= LAP;
      r_pclr <= CLEAR;
      // display tracks the count as it stood before this edge
      if (!r_hold) begin
        r_dmt <= r_mt;
        r_dmu <= r_mu;
        r_dst <= r_st;
        r_dsu <= r_su;
        r_dht <= r_ht;
        r_dhu <= r_hu;
      end
      if (w_clr) begin
        r_run  <= 1'b0;
        r_hold <= 1'b0;
        r_wrap <= 1'b0;
        r_mt   <= '0;
        r_mu   <= '0;
        r_st   <= '0;
        r_su   <= '0;
        r_ht   <= '0;
        r_hu   <= '0;
      end else begin
        r_wrap <= w_wrap;
        if (w_ss)  r_run  <= ~r_run;
        if (w_lap) r_hold <= ~r_hold;
        if (w_c0)  r_hu   <= f_inc(r_hu, 4'd9);
        if (w_c1)  r_ht   <= f_inc(r_ht, 4'd9);
        if (w_c2)  r_su   <= f_inc(r_su, 4'd9);
        if (w_c3)  r_st   <= f_inc(r_st, 4'd5);
        if (w_c4)  r_mu   <= w_mu_roll ? 4'd0 : r_mu + 4'd1;
        if (w_c4 && w_mu_roll)
          r_mt <= w_min_top ? 4'd0 : r_mt + 4'd1;
      end
    end
  end

  assign MIN_T    = r_dmt;
  assign MIN_U    = r_dmu;
  assign SEC_T    = r_dst;
  assign SEC_U    = r_dsu;
  assign HUN_T    = r_dht;
  assign HUN_U    = r_dhu;
  assign RUNNING  = r_run;
  assign LAP_HOLD = r_hold;
  assign WRAP     = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (60 and 2 minute wrap)
// checked each cycle against an integer-hundredths model.
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c100 = 1'b0, ss = 1'b0, lap = 1'b0, clr = 1'b0;

  logic [3:0] mt6, mu6, st6, su6, ht6, hu6;
  logic [3:0] mt2, mu2, st2, su2, ht2, hu2;
  logic       run6, hold6, wrap6, run2, hold2, wrap2;

  int checks = 0;
  int failures = 0;
  int nwrap6 = 0;
  int nwrap2 = 0;

  always #5 clk = ~clk;

  stopwatch_bcd #(.MIN_WRAP(60)) u_d60 (
    .CLOCK_10MHz(clk), .RESET_N(rst_n), .CLOCK_100Hz(c100),
    .START_STOP(ss), .LAP(lap), .CLEAR(clr),
    .MIN_T(mt6), .MIN_U(mu6), .SEC_T(st6), .SEC_U(su6),
    .HUN_T(ht6), .HUN_U(hu6),
    .RUNNING(run6), .LAP_HOLD(hold6), .WRAP(wrap6)
  );

  stopwatch_bcd #(.MIN_WRAP(2)) u_d2 (
    .CLOCK_10MHz(clk), .RESET_N(rst_n), .CLOCK_100Hz(c100),
    .START_STOP(ss), .LAP(lap), .CLEAR(clr),
    .MIN_T(mt2), .MIN_U(mu2), .SEC_T(st2), .SEC_U(su2),
    .HUN_T(ht2), .HUN_U(hu2),
    .RUNNING(run2), .LAP_HOLD(hold2), .WRAP(wrap2)
  );

  wire [26:0] a6 = {mt6, mu6, st6, su6, ht6, hu6, run6, hold6, wrap6};
  wire [26:0] a2 = {mt2, mu2, st2, su2, ht2, hu2, run2, hold2, wrap2};

  // Model: counts held as total hundredths, displayed via division.
  int  m_cnt6, m_cnt2, m_disp6, m_disp2;
  bit  m_run, m_hold, m_wrap6, m_wrap2;
  bit  p100, pss, plap, pclr;

  function automatic logic [23:0] digits(input int t);
    int m, s, h;
    m = t / 6000;
    s = (t / 100) % 60;
    h = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(h / 10), 4'(h % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt6 = 0; m_cnt2 = 0; m_disp6 = 0; m_disp2 = 0;
      m_run = 0; m_hold = 0; m_wrap6 = 0; m_wrap2 = 0;
      p100 = 1; pss = 1; plap = 1; pclr = 1;
    end else begin
      bit tk, es, el, ec;
      tk = c100 & ~p100;
      es = ss & ~pss;
      el = lap & ~plap;
      ec = clr & ~pclr;
      if (!m_hold) begin
        m_disp6 = m_cnt6;
        m_disp2 = m_cnt2;
      end
      m_wrap6 = 0;
      m_wrap2 = 0;
      if (ec) begin
        m_cnt6 = 0; m_cnt2 = 0; m_run = 0; m_hold = 0;
      end else begin
        if (tk && m_run) begin
          m_cnt6 = (m_cnt6 + 1) % (60 * 6000);
          m_cnt2 = (m_cnt2 + 1) % (2 * 6000);
          m_wrap6 = (m_cnt6 == 0);
          m_wrap2 = (m_cnt2 == 0);
        end
        if (es) m_run = ~m_run;
        if (el) m_hold = ~m_hold;
      end
      p100 = c100; pss = ss; plap = lap; pclr = clr;
    end
  end

  task automatic chk(input string nm, input logic [26:0] act,
                     input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model60", a6, {digits(m_disp6), m_run, m_hold, m_wrap6});
      chk("model2", a2, {digits(m_disp2), m_run, m_hold, m_wrap2});
      if (wrap6) nwrap6++;
      if (wrap2) nwrap2++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      c100 = 1'b1;
      @(negedge clk);
      c100 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_ss();
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset60", a6, 27'd0);
    chk("reset2", a2, 27'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // run 123 ticks
    pulse_ss();
    tick(123);
    @(negedge clk);
    chk("t1_disp", a6, {24'h000123, 3'b100});
    chk("t1_nowrap", 27'(nwrap6), 27'd0);

    // ticks while stopped are ignored
    pulse_clr();
    pulse_ss();
    tick(50);
    pulse_ss();
    tick(20);
    pulse_ss();
    tick(10);
    @(negedge clk);
    chk("t2_disp", a6, {24'h000060, 3'b100});

    // 2-minute wrap
    pulse_clr();
    pulse_ss();
    tick(11999);
    @(negedge clk);
    chk("t3_pre2", a2, {24'h015999, 3'b100});
    c100 = 1'b1;
    @(negedge clk);
    chk("t3_wrap_on", {26'd0, wrap2}, 27'd1);
    c100 = 1'b0;
    @(negedge clk);
    chk("t3_wrap_off", a2, {24'h000000, 3'b100});
    @(negedge clk);
    chk("t3_post60", a6, {24'h020000, 3'b100});
    chk("t3_nwrap2", 27'(nwrap2), 27'd1);

    // lap freeze and release
    pulse_clr();
    pulse_ss();
    tick(30);
    pulse_lap();
    tick(70);
    @(negedge clk);
    chk("t4_hold", a6, {24'h000030, 3'b110});
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    @(negedge clk);
    chk("t4_release", a6, {24'h000100, 3'b100});

    // clear beats everything in the same cycle
    pulse_clr();
    pulse_ss();
    tick(500);
    @(negedge clk);
    chk("t5_pre", a6, {24'h000500, 3'b100});
    clr = 1'b1; ss = 1'b1; lap = 1'b1; c100 = 1'b1;
    @(negedge clk);
    clr = 1'b0; ss = 1'b0; lap = 1'b0; c100 = 1'b0;
    @(negedge clk);
    chk("t5_clear", a6, {24'h000000, 3'b000});

    // async reset mid-count with START_STOP held high
    pulse_ss();
    tick(7);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async60", a6, 27'd0);
    chk("t6_async2", a2, 27'd0);
    ss = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_noedge", a6, 27'd0);
    ss = 1'b0;
    @(negedge clk);

    // stop coincident with tick counts that tick
    pulse_ss();
    tick(9);
    c100 = 1'b1; ss = 1'b1;
    @(negedge clk);
    c100 = 1'b0; ss = 1'b0;
    @(negedge clk);
    tick(5);
    @(negedge clk);
    chk("t6_stop", a6, {24'h000010, 3'b000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
